// File: rtl/subpel_pkg.sv
`default_nettype none
// ============================================================================
// Module  : subpel_pkg
// Brief   : Shared widths, HEVC luma quarter-sample taps and pixel clipping.
// Rev     : 1.0  initial release
// ============================================================================
package subpel_pkg;

    localparam int PIX_W = 8;
    localparam int H_W   = 16;
    localparam int V_W   = 24;

    typedef logic signed [7:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic signed [V_W-1:0] c_pix_max = V_W'(255);

    function automatic coef_t coef(input logic [1:0] frac, input logic [2:0] tap);
        coef_t tbl [8];
        case (frac)
            2'd1:    tbl = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
            2'd2:    tbl = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
            2'd3:    tbl = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
            default: tbl = '{8'sd0, 8'sd0, 8'sd0, 8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        endcase
        return tbl[tap];
    endfunction

    function automatic logic [PIX_W-1:0] clip8(input logic signed [V_W-1:0] x);
        if (x[V_W-1])
            return '0;
        else if (x > c_pix_max)
            return {PIX_W{1'b1}};
        else
            return x[PIX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/subpel_fir8.sv
`default_nettype none
// ============================================================================
// Module  : subpel_fir8
// Brief   : Combinational 8-tap dot product against the selected fraction taps.
// Rev     : 1.0  initial release
// ============================================================================
module subpel_fir8
    import subpel_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter bit IN_SIGNED = 1'b0,
    parameter int ACC_W     = 16
) (
    input  logic [1:0]              frac,
    input  logic [8*IN_W-1:0]       taps_in,
    output logic signed [ACC_W-1:0] acc
);

    always_comb begin
        logic signed [ACC_W-1:0] smp;
        logic signed [ACC_W-1:0] cf;
        acc = '0;
        smp = '0;
        cf  = '0;
        for (int t = 0; t < 8; t++) begin
            if (IN_SIGNED)
                smp = ACC_W'($signed(taps_in[t*IN_W +: IN_W]));
            else
                smp = ACC_W'(taps_in[t*IN_W +: IN_W]);
            cf  = ACC_W'(coef(frac, 3'(t)));
            acc = acc + smp * cf;
        end
    end

endmodule
`default_nettype wire

// File: rtl/subpel_interp_2d.sv
`default_nettype none
// ============================================================================
// Module  : subpel_interp_2d
// Brief   : HEVC 8-bit luma quarter-sample separable interpolator, row streaming.
// Rev     : 1.0  initial release
// ============================================================================
module subpel_interp_2d
    import subpel_pkg::*;
#(
    parameter int BLK_W = 8,
    parameter int BLK_H = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   frac_x,
    input  logic [1:0]                   frac_y,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [(BLK_W+7)*PIX_W-1:0]   in_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BLK_W*PIX_W-1:0]       out_row,
    output logic                         out_last,
    output logic                         done
);

    localparam int ROWS_IN = BLK_H + 7;
    localparam int CNT_W   = $clog2(ROWS_IN + 1);
    localparam logic signed [V_W-1:0] c_round = V_W'(32);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_frac_x;
    logic [1:0]             r_frac_y;
    logic [CNT_W-1:0]       r_in_cnt;
    logic [CNT_W-1:0]       r_out_cnt;
    // Seven history rows plus the incoming row form the 8-row vertical window.
    logic [BLK_W*H_W-1:0]   r_hist [8];
    logic [BLK_W*H_W-1:0]   w_h_row;
    logic [BLK_W*PIX_W-1:0] w_v_pix;
    logic                   w_in_fire;
    logic                   w_out_fire;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    generate
        for (genvar j = 0; j < BLK_W; j++) begin : g_col
            logic signed [H_W-1:0] w_h_col;
            logic signed [V_W-1:0] w_v;
            logic signed [V_W-1:0] w_v14;
            logic signed [V_W-1:0] w_rnd;
            logic [8*H_W-1:0]      w_vin;

            subpel_fir8 #(.IN_W(PIX_W), .IN_SIGNED(1'b0), .ACC_W(H_W)) u_hfir (
                .frac    (r_frac_x),
                .taps_in (in_row[j*PIX_W +: 8*PIX_W]),
                .acc     (w_h_col)
            );

            assign w_h_row[j*H_W +: H_W] = w_h_col;
            assign w_vin = {w_h_col,
                            r_hist[6][j*H_W +: H_W], r_hist[5][j*H_W +: H_W],
                            r_hist[4][j*H_W +: H_W], r_hist[3][j*H_W +: H_W],
                            r_hist[2][j*H_W +: H_W], r_hist[1][j*H_W +: H_W],
                            r_hist[0][j*H_W +: H_W]};

            subpel_fir8 #(.IN_W(H_W), .IN_SIGNED(1'b1), .ACC_W(V_W)) u_vfir (
                .frac    (r_frac_y),
                .taps_in (w_vin),
                .acc     (w_v)
            );

            assign w_v14 = w_v >>> 6;
            assign w_rnd = (w_v14 + c_round) >>> 6;
            assign w_v_pix[j*PIX_W +: PIX_W] = clip8(w_rnd);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && (r_in_cnt == CNT_W'(6)))
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = (r_in_cnt != CNT_W'(ROWS_IN)) && (!out_valid || out_ready);
                if (out_valid && out_ready && out_last)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frac_x  <= '0;
            r_frac_y  <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            for (int i = 0; i < 8; i++)
                r_hist[i] <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_frac_x  <= frac_x;
                r_frac_y  <= frac_y;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end
            if (w_in_fire) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
                for (int i = 0; i < 6; i++)
                    r_hist[i] <= r_hist[i+1];
                r_hist[6] <= w_h_row;
            end
            if (w_in_fire && (r_state == ST_RUN)) begin
                out_row   <= w_v_pix;
                out_valid <= 1'b1;
                out_last  <= (r_out_cnt == CNT_W'(BLK_H - 1));
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end else if (w_out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_subpel_interp_2d.sv
`default_nettype none
// ============================================================================
// Module  : tb_subpel_interp_2d
// Brief   : Directed self-checking bench for the 2-D subpel interpolator.
// Rev     : 1.0  initial release
// ============================================================================
module tb_subpel_interp_2d;

    localparam int BW   = 8;
    localparam int BH   = 8;
    localparam int ROWS = BH + 7;
    localparam int COLS = BW + 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        frac_x = 2'd0;
    logic [1:0]        frac_y = 2'd0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [COLS*8-1:0] in_row = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BW*8-1:0]   out_row;
    logic              out_last;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]      img [ROWS][COLS];
    logic [BW*8-1:0] first_row;
    int              first_valid_cyc;
    int              eighth_in_cyc;

    int coef_tb [4][8] = '{'{0, 0, 0, 64, 0, 0, 0, 0},
                           '{-1, 4, -10, 58, 17, -5, 1, 0},
                           '{-1, 4, -11, 40, 40, -11, 4, -1},
                           '{0, 1, -5, 17, 58, -10, 4, -1}};

    subpel_interp_2d #(.BLK_W(BW), .BLK_H(BH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frac_x    (frac_x),
        .frac_y    (frac_y),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [COLS*8-1:0] pack_row(input int r);
        logic [COLS*8-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++)
            v[c*8 +: 8] = img[r][c];
        return v;
    endfunction

    function automatic logic [BW*8-1:0] model_row(input int fx, input int fy, input int k);
        logic [BW*8-1:0] r;
        int h, v, o;
        r = '0;
        for (int j = 0; j < BW; j++) begin
            v = 0;
            for (int t = 0; t < 8; t++) begin
                h = 0;
                for (int u = 0; u < 8; u++)
                    h += coef_tb[fx][u] * int'(img[k+t][j+u]);
                v += coef_tb[fy][t] * h;
            end
            o = v >>> 6;
            o = (o + 32) >>> 6;
            if (o < 0) o = 0;
            if (o > 255) o = 255;
            r[j*8 +: 8] = o[7:0];
        end
        return r;
    endfunction

    // mode 0: golden model, 1: constant cval, 2: integer copy pixel(k+3, j+3)
    task automatic run_block(input logic [1:0] fx, input logic [1:0] fy, input int mode,
                             input int cval, input int max_in,
                             input int stall_at, input int stall_len);
        int in_idx, out_idx, cyc;
        logic in_f, out_f, have_held;
        logic [BW*8-1:0] held, exp_row;
        in_idx = 0; out_idx = 0; cyc = 0; have_held = 1'b0; held = '0;
        first_valid_cyc = -1; eighth_in_cyc = -1;
        frac_x = fx; frac_y = fy; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (out_idx < BH && cyc < 400) begin
            if (max_in < ROWS && in_idx >= max_in) break;
            start     = (cyc == 3);
            frac_x    = fx ^ 2'b11;
            frac_y    = fy ^ 2'b10;
            in_valid  = (in_idx < max_in);
            in_row    = pack_row(in_idx < ROWS ? in_idx : 0);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (in_f && in_idx == 7) eighth_in_cyc = cyc;
            if (out_valid && !out_ready) begin
                check($sformatf("stall_in_ready c%0d", cyc), in_ready, 0);
                if (have_held) check($sformatf("stall_hold c%0d", cyc), out_row, held);
                held = out_row;
                have_held = 1'b1;
            end
            if (out_f) begin
                have_held = 1'b0;
                if (mode == 1)
                    exp_row = {BW{cval[7:0]}};
                else if (mode == 2)
                    for (int j = 0; j < BW; j++) exp_row[j*8 +: 8] = img[out_idx+3][j+3];
                else
                    exp_row = model_row(int'(fx), int'(fy), out_idx);
                if (out_idx == 0) first_row = out_row;
                check($sformatf("row%0d f%0d%0d", out_idx, fx, fy), out_row, exp_row);
                check($sformatf("last%0d f%0d%0d", out_idx, fx, fy), out_last, (out_idx == BH-1));
            end
            @(posedge clk);
            if (in_f) in_idx++;
            if (out_f) out_idx++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        frac_x = 2'd0; frac_y = 2'd0;
        if (max_in >= ROWS) begin
            check("rows_out", out_idx, BH);
            check("rows_in", in_idx, ROWS);
            #1;
            check("done_pulse", done, 1);
            check("busy_in_done", busy, 0);
            @(posedge clk);
            @(negedge clk);
            check("done_cleared", done, 0);
        end
    endtask

    initial begin
        // Asynchronous reset: outputs must clear without a clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_out_row", out_row, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Flat image at every fraction pair.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = 8'd100;
        for (int p = 0; p < 16; p++)
            run_block(2'(p >> 2), 2'(p & 3), 1, 100, ROWS, 999, 0);

        // Integer copy of a ramp and first-output latency.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = 8'((r*15 + c) % 256);
        run_block(2'd0, 2'd0, 2, 0, ROWS, 999, 0);
        check("first_valid_latency", first_valid_cyc, eighth_in_cyc + 1);

        // Half-pel step edge: 255*32 rounds to 128.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = (c < 4) ? 8'd0 : 8'd255;
        run_block(2'd2, 2'd0, 0, 0, ROWS, 999, 0);
        check("step_px0", first_row[7:0], 8'd128);

        // Overshoot clips high: 255*80/64 > 255.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = (c == 3 || c == 4) ? 8'd255 : 8'd0;
        run_block(2'd2, 2'd0, 0, 0, ROWS, 999, 0);
        check("clip_hi_px0", first_row[7:0], 8'd255);

        // Undershoot clips low: -10*255 is negative.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = (c == 2) ? 8'd255 : 8'd0;
        run_block(2'd1, 2'd0, 0, 0, ROWS, 999, 0);
        check("clip_lo_px0", first_row[7:0], 8'd0);

        // 2-D checkerboard with a 5-cycle downstream stall.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = ((r + c) % 2 == 1) ? 8'd255 : 8'd0;
        run_block(2'd2, 2'd2, 0, 0, ROWS, 10, 5);

        // Reset mid-block after 10 rows, then a fresh block.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = 8'((r*15 + c) % 256);
        run_block(2'd2, 2'd2, 0, 0, 10, 999, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_out_row", out_row, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        check("idle_in_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        run_block(2'd3, 2'd1, 0, 0, ROWS, 999, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
